// File: rtl/dsp_issue_ctrl_pkg.sv
// Shared definitions for the DSP issue controller.
// Provides the DSP mode encoding, the issue FSM state type and op_len(),
// which returns the number of issue cycles each mode occupies.
package dsp_issue_ctrl_pkg;

    localparam logic [1:0] MODE_SINGLE  = 2'd0;  // 9x9, one cycle
    localparam logic [1:0] MODE_HALF    = 2'd1;  // 9x16, two cycles
    localparam logic [1:0] MODE_FULL    = 2'd2;  // 16x16, four cycles
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;  // issued as MODE_SINGLE

    typedef enum logic [0:0] {StIdle, StRun} issue_state_e;

    // Issue length L in cycles; the illegal mode runs as a single-cycle op.
    function automatic logic [2:0] op_len(input logic [1:0] mode);
        logic [2:0] len;
        len = 3'd1;
        unique case (mode)
            MODE_SINGLE: len = 3'd1;
            MODE_HALF:   len = 3'd2;
            MODE_FULL:   len = 3'd4;
            default:     len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/dsp_issue_ctrl_if.sv
// Request channel of the DSP issue controller.
// Ports (signals):
//   in_valid / in_ready : valid/ready handshake, transfer when both are high
//   in_a, in_b, in_c    : operands and addend
//   in_mode, in_mac     : DSP mode and accumulate-onto-previous flag
//   in_shamt, in_shdir  : feedback shift amount and direction
// Modports: master drives the request, slave (the controller) returns in_ready.
interface dsp_issue_ctrl_if #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [M-1:0]     in_b;
    logic [N+M-1:0]   in_c;
    logic [1:0]       in_mode;
    logic             in_mac;
    logic [1:0]       in_shamt;
    logic             in_shdir;

    modport master (
        output in_valid, in_a, in_b, in_c, in_mode, in_mac, in_shamt, in_shdir,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_mode, in_mac, in_shamt, in_shdir,
        output in_ready
    );
endinterface

// File: rtl/dsp_op_slot.sv
// One registered op record (operands, mode, mac, shift controls, valid bit).
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   load           : capture the d_* fields and set valid (wins over clr)
//   clr            : drop valid; fields are kept so downstream pins stay held
//   d_* / q_*      : record input / registered record output
//   valid          : slot holds an op
module dsp_op_slot #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clr,
    input  logic [N-1:0]     d_a,
    input  logic [M-1:0]     d_b,
    input  logic [N+M-1:0]   d_c,
    input  logic [1:0]       d_mode,
    input  logic             d_mac,
    input  logic [1:0]       d_shamt,
    input  logic             d_shdir,
    output logic [N-1:0]     q_a,
    output logic [M-1:0]     q_b,
    output logic [N+M-1:0]   q_c,
    output logic [1:0]       q_mode,
    output logic             q_mac,
    output logic [1:0]       q_shamt,
    output logic             q_shdir,
    output logic             valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_a     <= '0;
            q_b     <= '0;
            q_c     <= '0;
            q_mode  <= '0;
            q_mac   <= 1'b0;
            q_shamt <= '0;
            q_shdir <= 1'b0;
            valid   <= 1'b0;
        end else if (load) begin
            q_a     <= d_a;
            q_b     <= d_b;
            q_c     <= d_c;
            q_mode  <= d_mode;
            q_mac   <= d_mac;
            q_shamt <= d_shamt;
            q_shdir <= d_shdir;
            valid   <= 1'b1;
        end else if (clr) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/dsp_issue_ctrl.sv
// Operand sequencer feeding the fractured DSP datapath.
// Accepts multiply / multiply-accumulate requests, holds the operands on the
// DSP pins for the op's issue length, sequences start/mac, and captures the
// DSP result RES_LAT cycles after the op's last issue cycle.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req                   : request channel (slave side)
//   dsp_start, dsp_mac    : DSP start strobe and chain-accumulate control
//   dsp_mode, dsp_shift_* : DSP mode and feedback shift controls
//   dsp_pipe_stages       : constant PIPES
//   dsp_aa, dsp_bb, dsp_cc: operands / addend held across the op
//   dsp_out               : DSP result
//   res_valid, res_data   : one-cycle result strobe and held result
//   acc_break, err_mode   : mac op could not chain / illegal mode issued
module dsp_issue_ctrl
    import dsp_issue_ctrl_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned M       = 16,
    parameter int unsigned RES_LAT = 1,
    parameter int unsigned PIPES   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    dsp_issue_ctrl_if.slave  req,
    output logic             dsp_start,
    output logic             dsp_mac,
    output logic             dsp_shift_dir,
    output logic [1:0]       dsp_mode,
    output logic [1:0]       dsp_shift_amount,
    output logic [1:0]       dsp_pipe_stages,
    output logic [N-1:0]     dsp_aa,
    output logic [M-1:0]     dsp_bb,
    output logic [N+M-1:0]   dsp_cc,
    input  logic [N+M-1:0]   dsp_out,
    output logic             res_valid,
    output logic [N+M-1:0]   res_data,
    output logic             acc_break,
    output logic             err_mode
);

    issue_state_e   state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           first_q;
    logic           mac_prev_q;
    logic [RES_LAT-1:0] vld_pipe_q;

    logic           accept, cur_load, last;

    logic [N-1:0]   pend_a;
    logic [M-1:0]   pend_b;
    logic [N+M-1:0] pend_c;
    logic [1:0]     pend_mode, pend_shamt;
    logic           pend_mac, pend_shdir, pend_valid;

    logic [1:0]     cur_mode;
    logic           cur_mac, cur_valid;

    assign last         = (state_q == StRun) && (cnt_q == 2'd0);
    assign cur_load     = pend_valid && ((state_q == StIdle) || last);
    assign req.in_ready = !pend_valid || cur_load;
    assign accept       = req.in_valid && req.in_ready;

    dsp_op_slot #(.N(N), .M(M)) u_pend (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .clr     (cur_load),
        .d_a     (req.in_a),
        .d_b     (req.in_b),
        .d_c     (req.in_c),
        .d_mode  (req.in_mode),
        .d_mac   (req.in_mac),
        .d_shamt (req.in_shamt),
        .d_shdir (req.in_shdir),
        .q_a     (pend_a),
        .q_b     (pend_b),
        .q_c     (pend_c),
        .q_mode  (pend_mode),
        .q_mac   (pend_mac),
        .q_shamt (pend_shamt),
        .q_shdir (pend_shdir),
        .valid   (pend_valid)
    );

    // cur fields stay put after the op so the DSP pins hold in IDLE.
    dsp_op_slot #(.N(N), .M(M)) u_cur (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cur_load),
        .clr     (last),
        .d_a     (pend_a),
        .d_b     (pend_b),
        .d_c     (pend_c),
        .d_mode  (pend_mode),
        .d_mac   (pend_mac),
        .d_shamt (pend_shamt),
        .d_shdir (pend_shdir),
        .q_a     (dsp_aa),
        .q_b     (dsp_bb),
        .q_c     (dsp_cc),
        .q_mode  (cur_mode),
        .q_mac   (cur_mac),
        .q_shamt (dsp_shift_amount),
        .q_shdir (dsp_shift_dir),
        .valid   (cur_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cur_load) begin
                    state_d = StRun;
                    cnt_d   = 2'(op_len(pend_mode) - 3'd1);
                end
            end
            StRun: begin
                if (last) begin
                    if (cur_load) begin
                        cnt_d = 2'(op_len(pend_mode) - 3'd1);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            mac_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= cur_load;
            mac_prev_q <= dsp_mac;
        end
    end

    // cur_valid is always set in RUN; it only guards the strobe.
    assign dsp_start = (state_q == StRun) && first_q && cur_valid;
    assign dsp_mode  = (cur_mode == MODE_ILLEGAL) ? MODE_SINGLE : cur_mode;
    // Raise mac on the last cycle when the next op wants to chain, so the DSP
    // keeps its accumulator for that op's start.
    assign dsp_mac   = (dsp_start && cur_mac) || (last && pend_valid && pend_mac);
    assign acc_break = dsp_start && cur_mac && !mac_prev_q;
    assign err_mode  = dsp_start && (cur_mode == MODE_ILLEGAL);
    assign dsp_pipe_stages = 2'(PIPES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            vld_pipe_q[0] <= last;
            for (int i = 1; i < int'(RES_LAT); i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
            res_valid <= vld_pipe_q[RES_LAT-1];
            if (vld_pipe_q[RES_LAT-1]) begin
                res_data <= dsp_out;
            end
        end
    end

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Directed bench for dsp_issue_ctrl with a behavioural DSP: on each start it
// computes aa*bb plus either cc or, when mac was held across the boundary,
// its previous result.
module tb_dsp_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dsp_start, dsp_mac, dsp_shift_dir, res_valid, acc_break, err_mode;
    logic [1:0]  dsp_mode, dsp_shift_amount, dsp_pipe_stages;
    logic [15:0] dsp_aa, dsp_bb;
    logic [31:0] dsp_cc, res_data;
    logic [31:0] dsp_out = '0;
    logic        mdl_mac_prev = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    dsp_issue_ctrl_if #(.N(16), .M(16)) req ();

    dsp_issue_ctrl #(.N(16), .M(16), .RES_LAT(1), .PIPES(0)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .dsp_start        (dsp_start),
        .dsp_mac          (dsp_mac),
        .dsp_shift_dir    (dsp_shift_dir),
        .dsp_mode         (dsp_mode),
        .dsp_shift_amount (dsp_shift_amount),
        .dsp_pipe_stages  (dsp_pipe_stages),
        .dsp_aa           (dsp_aa),
        .dsp_bb           (dsp_bb),
        .dsp_cc           (dsp_cc),
        .dsp_out          (dsp_out),
        .res_valid        (res_valid),
        .res_data         (res_data),
        .acc_break        (acc_break),
        .err_mode         (err_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mdl_mac_prev <= dsp_mac;
        if (dsp_start) begin
            dsp_out <= 32'(dsp_aa) * 32'(dsp_bb) + ((dsp_mac && mdl_mac_prev) ? dsp_out : dsp_cc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                         input logic [1:0] mode, input logic mac,
                         input logic [1:0] shamt, input logic shdir);
        req.in_valid = 1'b1;
        req.in_a     = a;
        req.in_b     = b;
        req.in_c     = c;
        req.in_mode  = mode;
        req.in_mac   = mac;
        req.in_shamt = shamt;
        req.in_shdir = shdir;
    endtask

    initial begin
        drive(16'd0, 16'd0, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        req.in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_in_ready", 32'(req.in_ready), 32'd1);
        chk("rst_start", 32'(dsp_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_aa", 32'(dsp_aa), 32'd0);
        chk("pipe_stages", 32'(dsp_pipe_stages), 32'd0);

        // 1: mode 0, 3*5
        drive(16'd3, 16'd5, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        tick();
        req.in_valid = 1'b0;
        chk("t1_no_start_c1", 32'(dsp_start), 32'd0);
        tick();
        chk("t1_start", 32'(dsp_start), 32'd1);
        chk("t1_aa", 32'(dsp_aa), 32'd3);
        chk("t1_bb", 32'(dsp_bb), 32'd5);
        tick();
        chk("t1_start_low", 32'(dsp_start), 32'd0);
        chk("t1_rv_early", 32'(res_valid), 32'd0);
        tick();
        chk("t1_rv", 32'(res_valid), 32'd1);
        chk("t1_data", res_data, 32'd15);
        tick();
        chk("t1_rv_pulse", 32'(res_valid), 32'd0);
        chk("t1_data_held", res_data, 32'd15);
        chk("t1_aa_held", 32'(dsp_aa), 32'd3);

        // 2: mode 2, four-cycle op, follow-up op waits
        drive(16'h1234, 16'h5678, 32'd0, 2'd2, 1'b0, 2'd3, 1'b1);
        tick();
        req.in_valid = 1'b0;
        tick();
        chk("t2_start", 32'(dsp_start), 32'd1);
        chk("t2_mode", 32'(dsp_mode), 32'd2);
        chk("t2_shamt", 32'(dsp_shift_amount), 32'd3);
        chk("t2_shdir", 32'(dsp_shift_dir), 32'd1);
        drive(16'd1, 16'd1, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        tick();
        req.in_valid = 1'b0;
        chk("t2_c2_start", 32'(dsp_start), 32'd0);
        chk("t2_c2_aa", 32'(dsp_aa), 32'h1234);
        chk("t2_c2_ready", 32'(req.in_ready), 32'd0);
        tick();
        chk("t2_c3_start", 32'(dsp_start), 32'd0);
        chk("t2_c3_bb", 32'(dsp_bb), 32'h5678);
        tick();
        chk("t2_c4_start", 32'(dsp_start), 32'd0);
        chk("t2_c4_ready", 32'(req.in_ready), 32'd1);
        chk("t2_c4_mac", 32'(dsp_mac), 32'd0);
        chk("t2_c4_aa", 32'(dsp_aa), 32'h1234);
        tick();
        chk("t2_next_start", 32'(dsp_start), 32'd1);
        chk("t2_next_aa", 32'(dsp_aa), 32'd1);
        chk("t2_next_shamt", 32'(dsp_shift_amount), 32'd0);
        tick();
        chk("t2_rv", 32'(res_valid), 32'd1);
        chk("t2_data", res_data, 32'h06260060);
        tick();
        chk("t2_rv2", 32'(res_valid), 32'd1);
        chk("t2_data2", res_data, 32'd1);
        tick();
        chk("t2_rv_low", 32'(res_valid), 32'd0);
        tick();

        // 3: back-to-back chained mac
        drive(16'd2, 16'd3, 32'd10, 2'd0, 1'b0, 2'd0, 1'b0);
        tick();
        drive(16'd4, 16'd5, 32'd0, 2'd0, 1'b1, 2'd0, 1'b0);
        tick();
        req.in_valid = 1'b0;
        chk("t3_op1_start", 32'(dsp_start), 32'd1);
        chk("t3_op1_mac", 32'(dsp_mac), 32'd1);
        chk("t3_op1_brk", 32'(acc_break), 32'd0);
        tick();
        chk("t3_op2_start", 32'(dsp_start), 32'd1);
        chk("t3_op2_aa", 32'(dsp_aa), 32'd4);
        chk("t3_op2_mac", 32'(dsp_mac), 32'd1);
        chk("t3_op2_brk", 32'(acc_break), 32'd0);
        tick();
        chk("t3_rv1", 32'(res_valid), 32'd1);
        chk("t3_data1", res_data, 32'd16);
        chk("t3_idle_mac", 32'(dsp_mac), 32'd0);
        tick();
        chk("t3_rv2", 32'(res_valid), 32'd1);
        chk("t3_data2", res_data, 32'd36);
        tick();
        tick();

        // 4: mac op after an idle gap cannot chain
        drive(16'd7, 16'd6, 32'd100, 2'd0, 1'b1, 2'd0, 1'b0);
        tick();
        req.in_valid = 1'b0;
        tick();
        chk("t4_start", 32'(dsp_start), 32'd1);
        chk("t4_brk", 32'(acc_break), 32'd1);
        tick();
        chk("t4_brk_pulse", 32'(acc_break), 32'd0);
        tick();
        chk("t4_rv", 32'(res_valid), 32'd1);
        chk("t4_data", res_data, 32'd142);
        tick();

        // 5: three mode-1 requests with in_valid held
        drive(16'd1, 16'd2, 32'd0, 2'd1, 1'b0, 2'd0, 1'b0);
        tick();
        chk("t5_c1_ready", 32'(req.in_ready), 32'd1);
        drive(16'd3, 16'd4, 32'd0, 2'd1, 1'b0, 2'd0, 1'b0);
        tick();
        chk("t5_c2_start", 32'(dsp_start), 32'd1);
        chk("t5_c2_aa", 32'(dsp_aa), 32'd1);
        chk("t5_c2_ready", 32'(req.in_ready), 32'd0);
        drive(16'd5, 16'd6, 32'd0, 2'd1, 1'b0, 2'd0, 1'b0);
        tick();
        chk("t5_c3_start", 32'(dsp_start), 32'd0);
        chk("t5_c3_aa", 32'(dsp_aa), 32'd1);
        chk("t5_c3_ready", 32'(req.in_ready), 32'd1);
        tick();
        req.in_valid = 1'b0;
        chk("t5_c4_start", 32'(dsp_start), 32'd1);
        chk("t5_c4_aa", 32'(dsp_aa), 32'd3);
        chk("t5_c4_ready", 32'(req.in_ready), 32'd0);
        tick();
        chk("t5_c5_start", 32'(dsp_start), 32'd0);
        chk("t5_rv1", 32'(res_valid), 32'd1);
        chk("t5_data1", res_data, 32'd2);
        tick();
        chk("t5_c6_start", 32'(dsp_start), 32'd1);
        chk("t5_c6_aa", 32'(dsp_aa), 32'd5);
        chk("t5_c6_rv", 32'(res_valid), 32'd0);
        tick();
        chk("t5_rv2", 32'(res_valid), 32'd1);
        chk("t5_data2", res_data, 32'd12);
        tick();
        chk("t5_c8_rv", 32'(res_valid), 32'd0);
        tick();
        chk("t5_rv3", 32'(res_valid), 32'd1);
        chk("t5_data3", res_data, 32'd30);
        tick();

        // 6: reset during the second cycle of a mode-2 op
        drive(16'd9, 16'd9, 32'd0, 2'd2, 1'b0, 2'd2, 1'b1);
        tick();
        req.in_valid = 1'b0;
        tick();
        chk("t6_start", 32'(dsp_start), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_aa", 32'(dsp_aa), 32'd0);
        chk("t6_rst_bb", 32'(dsp_bb), 32'd0);
        chk("t6_rst_mode", 32'(dsp_mode), 32'd0);
        chk("t6_rst_shamt", 32'(dsp_shift_amount), 32'd0);
        chk("t6_rst_shdir", 32'(dsp_shift_dir), 32'd0);
        chk("t6_rst_data", res_data, 32'd0);
        chk("t6_rst_ready", 32'(req.in_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_rv", 32'(res_valid), 32'd0);
            tick();
        end

        // mode 3 runs as mode 0 and flags err_mode
        drive(16'd3, 16'd4, 32'd1, 2'd3, 1'b0, 2'd0, 1'b0);
        tick();
        req.in_valid = 1'b0;
        tick();
        chk("t6_m3_start", 32'(dsp_start), 32'd1);
        chk("t6_m3_err", 32'(err_mode), 32'd1);
        chk("t6_m3_mode", 32'(dsp_mode), 32'd0);
        tick();
        chk("t6_m3_err_pulse", 32'(err_mode), 32'd0);
        chk("t6_m3_start_low", 32'(dsp_start), 32'd0);
        tick();
        chk("t6_m3_rv", 32'(res_valid), 32'd1);
        chk("t6_m3_data", res_data, 32'd13);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
